// File: rtl/seq_divider_hl.sv
// rtl/seq_divider_hl.sv - sequential restoring divider, N-bit dividend by N/2-bit divisor
module seq_divider_hl #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   dividend,
   input  logic [N/2-1:0] divisor,
   output logic           busy,
   output logic           done,
   output logic           ovf,
   output logic [N/2-1:0] quotient,
   output logic [N/2-1:0] remainder
);
   localparam int H  = N / 2;
   localparam int CW = $clog2(H + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [N-1:0]   r_w;
   logic [H-1:0]   r_d;
   logic [CW-1:0]  r_cnt;
   logic           r_ovf;
   logic [H-1:0]   r_quot;
   logic [H-1:0]   r_rem;

   logic           w_ovf_cond;
   logic [H:0]     w_t;
   logic [H:0]     w_diff;
   logic           w_ge;
   logic [H-1:0]   w_wh_next;
   logic [H-1:0]   w_wl_next;
   logic           w_last;

   // A quotient wider than H bits shows up as a high half already >= divisor.
   assign w_ovf_cond = (divisor == '0) || (dividend[N-1:H] >= divisor);

   assign w_t       = {r_w[N-1:H], r_w[H-1]};
   assign w_diff    = w_t - {1'b0, r_d};
   assign w_ge      = (w_t >= {1'b0, r_d});
   assign w_wh_next = w_ge ? w_diff[H-1:0] : w_t[H-1:0];
   assign w_wl_next = {r_w[H-2:0], w_ge};
   assign w_last    = (r_cnt == CW'(H - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = w_ovf_cond ? S_DONE : S_RUN;
         S_RUN:   if (w_last) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w    <= '0;
         r_d    <= '0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
         r_quot <= '0;
         r_rem  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_d   <= divisor;
                  r_cnt <= '0;
                  if (w_ovf_cond) begin
                     r_ovf  <= 1'b1;
                     r_quot <= '1;
                     r_rem  <= '0;
                  end else begin
                     r_w   <= dividend;
                     r_ovf <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               r_w   <= {w_wh_next, w_wl_next};
               r_cnt <= r_cnt + CW'(1);
               // Results are published only once the last quotient bit is in.
               if (w_last) begin
                  r_quot <= w_wl_next;
                  r_rem  <= w_wh_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign ovf       = r_ovf;
   assign quotient  = r_quot;
   assign remainder = r_rem;
endmodule

// File: tb/tb_seq_divider_hl.sv
// tb/tb_seq_divider_hl.sv - self-checking bench for seq_divider_hl
module tb_seq_divider_hl;
   localparam int N = 16;
   localparam int H = N / 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] dividend = '0;
   logic [H-1:0] divisor = '0;
   logic         busy, done, ovf;
   logic [H-1:0] quotient, remainder;

   int n_checks = 0;
   int n_errors = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   seq_divider_hl #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .ovf(ovf), .quotient(quotient), .remainder(remainder)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // {ovf, quotient, remainder} from plain integer division
   function automatic logic [2*H:0] ref_div(input int a, input int b);
      if (b == 0 || (a / b) > (2**H - 1)) return {1'b1, {H{1'b1}}, {H{1'b0}}};
      return {1'b0, H'(a / b), H'(a % b)};
   endfunction

   // Behavioural model: results appear after a fixed latency from acceptance.
   logic         m_busy = 0, m_done = 0, m_ovf = 0;
   logic [H-1:0] m_q = 0, m_r = 0, p_q = 0, p_r = 0;
   int           m_wait = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 0; m_done <= 0; m_ovf <= 0; m_q <= 0; m_r <= 0; m_wait <= 0;
      end else if (m_done) begin
         m_done <= 0; m_busy <= 0;
      end else if (m_busy) begin
         if (m_wait == 1) begin
            m_done <= 1; m_q <= p_q; m_r <= p_r;
         end
         m_wait <= m_wait - 1;
      end else if (start) begin
         m_busy <= 1;
         if (ref_div(int'(dividend), int'(divisor)) >> (2*H)) begin
            m_done <= 1; m_ovf <= 1; m_q <= '1; m_r <= '0;
         end else begin
            m_ovf  <= 0;
            m_wait <= H;
            p_q    <= ref_div(int'(dividend), int'(divisor)) >> H;
            p_r    <= ref_div(int'(dividend), int'(divisor));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk_en)
         chk("cycle {busy,done,ovf,q,r}", {busy, done, ovf, quotient, remainder},
             {m_busy, m_done, m_ovf, m_q, m_r});
   end

   task automatic run_op(input logic [N-1:0] a, input logic [H-1:0] b, input logic [H-1:0] eq,
                         input logic [H-1:0] er, input logic eo, input int elat, input string name);
      int lat;
      @(negedge clk);
      dividend = a; divisor = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, lat, elat);
      chk({name, "_q"}, quotient, eq);
      chk({name, "_r"}, remainder, er);
      chk({name, "_ovf"}, ovf, eo);
      chk({name, "_busy_at_done"}, busy, 1'b1);
      @(negedge clk);
      chk({name, "_idle_after"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int ndone;
      int k;
      logic [H-1:0] b;
      logic [N-1:0] a;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      chk("reset_outputs", {busy, done, ovf, quotient, remainder}, '0);

      // reset aborts a running division
      @(negedge clk);
      dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_mid_run", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", {busy, done, ovf, quotient, remainder}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("no_done_after_abort", ndone, 0);

      run_op(16'd1000, 8'd7,   8'd142, 8'd6,   1'b0, H + 1, "div_1000_7");
      run_op(16'hFEFF, 8'hFF,  8'hFF,  8'hFE,  1'b0, H + 1, "max_nonovf");
      run_op(16'hFF00, 8'hFF,  8'hFF,  8'h00,  1'b1, 1,     "ovf_wide");
      run_op(16'd5,    8'd0,   8'hFF,  8'h00,  1'b1, 1,     "ovf_div0");
      run_op(16'd0,    8'd3,   8'd0,   8'd0,   1'b0, H + 1, "zero_dividend");

      // start held high across a run; second start taken only from IDLE
      @(negedge clk);
      dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
      @(negedge clk);
      dividend = 16'd20000; divisor = 8'd200;
      ndone = 0;
      k = 0;
      while (ndone < 2 && k < 60) begin
         if (done) begin
            ndone++;
            if (ndone == 1) chk("held_first", {quotient, remainder}, {8'd142, 8'd6});
            if (ndone == 2) begin
               chk("held_second", {quotient, remainder}, {8'd100, 8'd0});
               start = 1'b0;
            end
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("held_done_count", ndone, 2);

      // randomized operations with operand churn while busy
      for (int i = 0; i < 80; i++) begin
         b = H'($urandom_range(0, 2**H - 1));
         if ($urandom_range(0, 9) == 0) b = '0;
         a = N'($urandom);
         if (b != 0 && $urandom_range(0, 2) != 0)
            a = {H'($urandom_range(0, int'(b) - 1)), H'($urandom)};
         @(negedge clk);
         dividend = a; divisor = b; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         k = 0;
         while (!done && k < 40) begin
            dividend = N'($urandom); divisor = H'($urandom);
            @(negedge clk);
            k++;
         end
         chk("rand_done_seen", done, 1'b1);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
